// File: rtl/decoder_seq_pkg.sv
// Shared definitions for the registered binary-to-one-hot decoder:
// FSM state type and the hold-counter width helper.
package decoder_seq_pkg;

    // Decoder control states; encodings match the original ST_IDLE/ST_HOLD values
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_e;

    // Hold counter width: max(1, clog2(hold)) so HOLD=1 still gets a 1-bit counter
    function automatic int unsigned cnt_width(input int unsigned hold);
        int unsigned w;
        w = $clog2(hold);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/decoder_seq_hold_counter.sv
// Loadable down-counter that times how long a decoded value stays on y.
// Counts down to zero and stops there; zero_o flags the final hold cycle.
module hold_counter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q;

    // Load has priority over decrement; the counter never wraps below zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/decoder_seq.sv
// Registered binary-to-one-hot decoder with a valid/ready input handshake.
// Each accepted in-range code is shown on y for exactly HOLD cycles; an
// out-of-range code produces a one-cycle err pulse and leaves y at zero.
// On the last hold cycle a new code may be accepted, giving back-to-back
// output values with no idle gap.
module decoder_seq
    import decoder_seq_pkg::*;
#(
    parameter int unsigned IN_W  = 3,
    parameter int unsigned OUT_N = 8,
    parameter int unsigned HOLD  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  code,
    output logic [OUT_N-1:0] y,
    output logic             y_valid,
    output logic             err,
    output logic             busy
);

    localparam int unsigned     CNT_W     = cnt_width(HOLD);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD - 1);
    // OUT_N can equal 2**IN_W, so compare in IN_W+1 bits
    localparam logic [IN_W:0]   OUT_N_EXT = (IN_W + 1)'(OUT_N);

    if (OUT_N < 1 || OUT_N > (1 << IN_W) || HOLD < 1) begin : g_param_check
        $error("decoder_seq: illegal parameters IN_W=%0d OUT_N=%0d HOLD=%0d",
               IN_W, OUT_N, HOLD);
    end

    state_e           state_q;
    logic [OUT_N-1:0] y_q;
    logic             y_valid_q;
    logic             err_q;

    logic [OUT_N-1:0] y_d;
    logic             code_ok;
    logic             accept;
    logic             cnt_zero;
    logic             cnt_load;
    logic             cnt_dec;

    // Handshake and status decode straight from state and the counter zero flag
    assign in_ready = (state_q == ST_IDLE) || cnt_zero;
    assign busy     = (state_q == ST_HOLD);
    assign accept   = in_valid && in_ready;
    assign code_ok  = ({1'b0, code} < OUT_N_EXT);

    // Decode the incoming code into its one-hot line
    always_comb begin
        y_d = '0;
        for (int unsigned i = 0; i < OUT_N; i++) begin
            y_d[i] = (code == IN_W'(i));
        end
    end

    // Counter restarts on every in-range accept and runs down only while holding
    assign cnt_load = accept && code_ok;
    assign cnt_dec  = busy && !cnt_zero;

    hold_counter #(
        .WIDTH (CNT_W)
    ) u_hold_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (HOLD_LOAD),
        .dec_i      (cnt_dec),
        .zero_o     (cnt_zero)
    );

    // Control FSM with registered y/y_valid/err; reset aborts any hold in progress
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (code_ok) begin
                            y_q       <= y_d;
                            y_valid_q <= 1'b1;
                            state_q   <= ST_HOLD;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (cnt_zero) begin
                        if (accept && code_ok) begin
                            // back-to-back: replace the value with no idle gap
                            y_q       <= y_d;
                            y_valid_q <= 1'b1;
                        end else begin
                            err_q     <= accept;
                            y_q       <= '0;
                            y_valid_q <= 1'b0;
                            state_q   <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    y_q       <= '0;
                    y_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign err     = err_q;

    // y carries at most one active line
    a_y_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(y_q));
    // an error response never coincides with valid data
    a_err_excl  : assert property (@(posedge clk) disable iff (!rst_n) !(err_q && y_valid_q));
    // y_valid marks exactly the cycles where a line is driven
    a_yv_match  : assert property (@(posedge clk) disable iff (!rst_n) y_valid_q == (y_q != '0));

endmodule

// File: tb/tb_decoder_seq.sv
// Bench for decoder_seq: three instances (HOLD=4/OUT_N=8, HOLD=4/OUT_N=6,
// HOLD=1/OUT_N=8). Each has a stimulus process that keeps a cycle-stamped
// reference of what must appear on the outputs and pushes it into a queue,
// and a monitor that pops and compares whenever the DUT presents data.
module tb_decoder_seq;

    int tests = 0;
    int fails = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cy;
        int yv;
        bit er;
    } exp_t;

    function automatic void chk(input int g, input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL inst%0d %s: got %0d expected %0d at %0t", g, nm, act, exp, $time);
        end
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_cfg
        localparam int unsigned HOLD_P = (g == 2) ? 1 : 4;
        localparam int unsigned OUTN_P = (g == 1) ? 6 : 8;

        logic              rst_n, in_valid, in_ready, y_valid, err, busy;
        logic [2:0]        code;
        logic [OUTN_P-1:0] y;

        exp_t q[$];
        int   cyc        = 0;
        int   last_cycle = -1;   // last cycle on which a value is shown
        bit   started    = 1'b0;
        bit   acc        = 1'b0;
        bit   fin        = 1'b0;

        decoder_seq #(
            .IN_W  (3),
            .OUT_N (OUTN_P),
            .HOLD  (HOLD_P)
        ) dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .code     (code),
            .y        (y),
            .y_valid  (y_valid),
            .err      (err),
            .busy     (busy)
        );

        // Drive one cycle of inputs and update the reference at the clock edge
        task automatic step(input bit r, input bit v, input int c);
            rst_n    = r;
            in_valid = v;
            code     = 3'(c);
            @(posedge clk);
            cyc++;
            acc = 1'b0;
            if (!r) begin
                q.delete();
                last_cycle = cyc - 1;
                started    = 1'b1;
            end else if (v && last_cycle <= cyc - 1) begin
                acc = 1'b1;
                if (c < int'(OUTN_P)) begin
                    for (int k = 0; k < int'(HOLD_P); k++)
                        q.push_back('{cyc + k, 1 << c, 1'b0});
                    last_cycle = cyc + int'(HOLD_P) - 1;
                end else begin
                    q.push_back('{cyc, 0, 1'b1});
                end
            end
            #1;
        endtask

        initial begin
            repeat (2) step(1'b0, 1'b1, int'($urandom_range(0, 7)));
            if (g == 0) begin
                for (int c = 0; c < 8; c++) begin
                    step(1'b1, 1'b1, c);
                    while (!acc) step(1'b1, 1'b1, c);
                end
                step(1'b1, 1'b1, 5);
                while (!acc) step(1'b1, 1'b1, 5);
                repeat (6) step(1'b1, 1'b0, 0);
                step(1'b1, 1'b1, 3);
                step(1'b1, 1'b0, 0);
                step(1'b0, 1'b0, 0);
                repeat (4) step(1'b1, 1'b0, 0);
            end else if (g == 1) begin
                step(1'b1, 1'b1, 6);
                step(1'b1, 1'b0, 0);
                step(1'b1, 1'b1, 7);
                step(1'b1, 1'b0, 0);
                step(1'b1, 1'b1, 2);
                repeat (5) step(1'b1, 1'b0, 0);
            end else begin
                step(1'b1, 1'b1, 1);
                step(1'b1, 1'b1, 2);
                step(1'b1, 1'b1, 3);
                step(1'b1, 1'b0, 0);
            end
            repeat (400)
                step($urandom_range(0, 49) != 0, $urandom_range(0, 2) != 0,
                     int'($urandom_range(0, 7)));
            repeat (HOLD_P + 2) step(1'b1, 1'b0, 0);
            fin = 1'b1;
        end

        always @(negedge clk) begin
            exp_t e;
            if (started) begin
                chk(g, "in_ready", int'(in_ready), int'(last_cycle <= cyc));
                chk(g, "busy", int'(busy), int'(last_cycle >= cyc));
                if (y_valid || err) begin
                    if (q.size() == 0) begin
                        chk(g, "unexpected_output", int'({err, y_valid}), 0);
                    end else begin
                        e = q.pop_front();
                        chk(g, "cycle", cyc, e.cy);
                        chk(g, "y", int'(y), e.yv);
                        chk(g, "err", int'(err), int'(e.er));
                        chk(g, "y_valid", int'(y_valid), int'(!e.er));
                    end
                end else begin
                    while (q.size() > 0 && q[0].cy <= cyc) begin
                        e = q.pop_front();
                        if (e.er) chk(g, "missing_err", int'(err), 1);
                        else      chk(g, "missing_y_valid", int'(y_valid), 1);
                    end
                    chk(g, "idle_y", int'(y), 0);
                end
            end
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        tests++;
        if (n >= 5000) begin
            fails++;
            $display("FAIL timeout: stimulus unfinished after %0d cycles, limit 5000", n);
        end
        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
